wb_track: RTL and testbench

Dual-lane writeback tracker producing the per-stage forwarding records that the issue-stage bypass network consumes. It follows each issued destination write through E, M1, M2 and M3 for both lanes. For every slot it presents the register written, whether the value is still pending (load/mul/hi/lo/cp0 result not yet available), and the data when known. It sits beside the execute/memory pipeline registers. It is the producer side of the bypass interface.

---
 rtl/wb_track.sv | 154 +++++++++++++++
 tb/tb_wb_track.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_track.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_track : dual-lane writeback tracker feeding the issue-stage bypass
//            network with per-stage (E, M1, M2, M3) forwarding records.
// Revision : 1.0
// ---------------------------------------------------------------------------
module wb_track #(
  parameter int NLANE = 2,
  parameter int DW    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic [NLANE-1:0]                iss_valid,
  input  logic [NLANE-1:0]                iss_regwrite,
  input  logic [NLANE-1:0][4:0]           iss_rdst,
  input  logic [NLANE-1:0]                iss_delayed,
  input  logic [NLANE-1:0][DW-1:0]        e_result,
  input  logic [NLANE-1:0]                late_valid,
  input  logic [NLANE-1:0][DW-1:0]        late_data,
  input  logic                            flush_e,
  input  logic                            flush_m1,
  output logic [4*NLANE-1:0]              byp_regwrite,
  output logic [4*NLANE-1:0][4:0]         byp_rdst,
  output logic [4*NLANE-1:0]              byp_pending,
  output logic [4*NLANE-1:0][DW-1:0]      byp_data,
  output logic                            m2_wait,
  output logic [2:0]                      pend_cnt
);

  localparam int NSTG = 4;
  localparam int ST_E  = 0;
  localparam int ST_M1 = 1;
  localparam int ST_M2 = 2;
  localparam int ST_M3 = 3;

  logic [NSTG-1:0][NLANE-1:0]         rw_q,   rw_d;
  logic [NSTG-1:0][NLANE-1:0]         pend_q, pend_d;
  logic [NSTG-1:0][NLANE-1:0][4:0]    rdst_q, rdst_d;
  logic [NSTG-1:0][NLANE-1:0][DW-1:0] data_q, data_d;

  logic             hold;
  logic [NLANE-1:0] issue_rw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q   <= '0;
      pend_q <= '0;
      rdst_q <= '0;
      data_q <= '0;
    end else begin
      rw_q   <= rw_d;
      pend_q <= pend_d;
      rdst_q <= rdst_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    hold   = stall | m2_wait;
    rw_d   = rw_q;
    pend_d = pend_q;
    rdst_d = rdst_q;
    data_d = data_q;
    for (int l = 0; l < NLANE; l++) begin
      issue_rw[l] = iss_valid[l] & iss_regwrite[l] & (iss_rdst[l] != 5'd0);
    end

    // In-place capture only matters while M2 is held; on advance M3 takes late_data directly
    for (int l = 0; l < NLANE; l++) begin
      if (pend_q[ST_M2][l] && late_valid[l]) begin
        pend_d[ST_M2][l] = 1'b0;
        data_d[ST_M2][l] = late_data[l];
      end
    end

    if (!hold) begin
      for (int l = 0; l < NLANE; l++) begin
        rw_d[ST_E][l]   = issue_rw[l];
        pend_d[ST_E][l] = issue_rw[l] & iss_delayed[l];
        rdst_d[ST_E][l] = issue_rw[l] ? iss_rdst[l] : 5'd0;
        data_d[ST_E][l] = '0;

        rw_d[ST_M1][l]   = rw_q[ST_E][l];
        pend_d[ST_M1][l] = pend_q[ST_E][l];
        rdst_d[ST_M1][l] = rdst_q[ST_E][l];
        data_d[ST_M1][l] = (rw_q[ST_E][l] && !pend_q[ST_E][l]) ? e_result[l] : '0;

        rw_d[ST_M2][l]   = rw_q[ST_M1][l];
        pend_d[ST_M2][l] = pend_q[ST_M1][l];
        rdst_d[ST_M2][l] = rdst_q[ST_M1][l];
        data_d[ST_M2][l] = data_q[ST_M1][l];

        rw_d[ST_M3][l]   = rw_q[ST_M2][l];
        pend_d[ST_M3][l] = 1'b0;
        rdst_d[ST_M3][l] = rdst_q[ST_M2][l];
        data_d[ST_M3][l] = pend_q[ST_M2][l] ? late_data[l] : data_q[ST_M2][l];
      end
    end

    for (int l = 0; l < NLANE; l++) begin
      if (flush_e || flush_m1) begin
        rw_d[ST_E][l]   = 1'b0;
        pend_d[ST_E][l] = 1'b0;
        rdst_d[ST_E][l] = 5'd0;
        data_d[ST_E][l] = '0;
      end
      if (flush_m1 || (flush_e && !hold)) begin
        rw_d[ST_M1][l]   = 1'b0;
        pend_d[ST_M1][l] = 1'b0;
        rdst_d[ST_M1][l] = 5'd0;
        data_d[ST_M1][l] = '0;
      end
      if (flush_m1 && !hold) begin
        rw_d[ST_M2][l]   = 1'b0;
        pend_d[ST_M2][l] = 1'b0;
        rdst_d[ST_M2][l] = 5'd0;
        data_d[ST_M2][l] = '0;
      end
    end
  end

  always_comb begin
    byp_regwrite = '0;
    byp_rdst     = '0;
    byp_pending  = '0;
    byp_data     = '0;
    for (int s = 0; s < NSTG; s++) begin
      for (int l = 0; l < NLANE; l++) begin
        byp_regwrite[s*NLANE+l] = rw_q[s][l];
        byp_rdst[s*NLANE+l]     = rdst_q[s][l];
        byp_pending[s*NLANE+l]  = pend_q[s][l];
        if (s == ST_E) begin
          byp_data[s*NLANE+l] = (rw_q[s][l] && !pend_q[s][l]) ? e_result[l] : '0;
        end else begin
          byp_data[s*NLANE+l] = data_q[s][l];
        end
      end
    end
  end

  assign m2_wait = |(pend_q[ST_M2] & ~late_valid);

  always_comb begin
    pend_cnt = 3'd0;
    for (int s = ST_E; s <= ST_M2; s++) begin
      for (int l = 0; l < NLANE; l++) begin
        pend_cnt = pend_cnt + 3'(pend_q[s][l]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_track.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_track : vector table with M3 scoreboard plus hand-written sequences
//               for holds, flushes and asynchronous reset.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_wb_track;
  localparam int NLANE = 2;
  localparam int DW    = 32;
  localparam int NVEC  = 7;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       stall;
  logic [NLANE-1:0]           iss_valid, iss_regwrite, iss_delayed;
  logic [NLANE-1:0][4:0]      iss_rdst;
  logic [NLANE-1:0][DW-1:0]   e_result;
  logic [NLANE-1:0]           late_valid;
  logic [NLANE-1:0][DW-1:0]   late_data;
  logic                       flush_e, flush_m1;
  logic [4*NLANE-1:0]         byp_regwrite;
  logic [4*NLANE-1:0][4:0]    byp_rdst;
  logic [4*NLANE-1:0]         byp_pending;
  logic [4*NLANE-1:0][DW-1:0] byp_data;
  logic                       m2_wait;
  logic [2:0]                 pend_cnt;

  always #5 clk = ~clk;

  wb_track #(.NLANE(NLANE), .DW(DW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .iss_valid(iss_valid), .iss_regwrite(iss_regwrite), .iss_rdst(iss_rdst),
    .iss_delayed(iss_delayed), .e_result(e_result),
    .late_valid(late_valid), .late_data(late_data),
    .flush_e(flush_e), .flush_m1(flush_m1),
    .byp_regwrite(byp_regwrite), .byp_rdst(byp_rdst), .byp_pending(byp_pending),
    .byp_data(byp_data), .m2_wait(m2_wait), .pend_cnt(pend_cnt)
  );

  typedef struct {
    logic [1:0]  valid, regwrite, delayed;
    logic [4:0]  rd0, rd1;
    logic [31:0] e0, e1;
    logic [1:0]  exp_rw, exp_pend;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  typedef struct packed {
    logic [1:0]       rw;
    logic [1:0][4:0]  rd;
    logic [1:0][31:0] d;
  } sb_t;

  vec_t vecs [NVEC];
  sb_t  sbq [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld(input int k, input int l);
    return 32'hC0DE_0000 | 32'(k << 4) | 32'(l);
  endfunction

  task automatic idle();
    iss_valid = '0; iss_regwrite = '0; iss_delayed = '0; iss_rdst = '0;
    e_result = '0; late_valid = '0; late_data = '0;
    stall = 1'b0; flush_e = 1'b0; flush_m1 = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v, input int k);
    sb_t e;
    logic [4:0] rd [2];
    logic [31:0] ev [2];
    iss_valid = v.valid; iss_regwrite = v.regwrite; iss_delayed = v.delayed;
    iss_rdst[0] = v.rd0; iss_rdst[1] = v.rd1;
    rd[0] = v.rd0; rd[1] = v.rd1; ev[0] = v.e0; ev[1] = v.e1;
    e = '0;
    for (int l = 0; l < 2; l++) begin
      e.rw[l] = v.valid[l] & v.regwrite[l] & (rd[l] != 5'd0);
      e.rd[l] = rd[l];
      e.d[l]  = !e.rw[l] ? 32'd0 : (v.delayed[l] ? ld(k, l) : ev[l]);
    end
    sbq.push_back(e);
  endtask

  task automatic issue1(input int l, input logic [4:0] rd, input logic dly);
    iss_valid = '0; iss_regwrite = '0; iss_delayed = '0; iss_rdst = '0;
    iss_valid[l] = 1'b1; iss_regwrite[l] = 1'b1; iss_delayed[l] = dly; iss_rdst[l] = rd;
  endtask

  initial begin
    sb_t exp;
    //          valid  regw   dly    rd0    rd1     e0            e1            rw     pend   d0            d1
    vecs[0] = '{2'b01, 2'b01, 2'b00, 5'd5,  5'd0,  32'h0000_1234, 32'h0,        2'b01, 2'b00, 32'h0000_1234, 32'h0};
    vecs[1] = '{2'b10, 2'b10, 2'b10, 5'd0,  5'd8,  32'h0,         32'h5555,     2'b10, 2'b10, 32'h0,         32'h0};
    vecs[2] = '{2'b11, 2'b11, 2'b00, 5'd0,  5'd0,  32'h77,        32'h88,       2'b00, 2'b00, 32'h0,         32'h0};
    vecs[3] = '{2'b11, 2'b11, 2'b01, 5'd9,  5'd31, 32'hAAAA,      32'hBBBB,     2'b11, 2'b01, 32'h0,         32'hBBBB};
    vecs[4] = '{2'b00, 2'b11, 2'b11, 5'd4,  5'd6,  32'h1,         32'h2,        2'b00, 2'b00, 32'h0,         32'h0};
    vecs[5] = '{2'b11, 2'b01, 2'b00, 5'd12, 5'd13, 32'hC,         32'hD,        2'b01, 2'b00, 32'hC,         32'h0};
    vecs[6] = '{2'b11, 2'b11, 2'b11, 5'd2,  5'd3,  32'hE,         32'hF,        2'b11, 2'b11, 32'h0,         32'h0};

    idle();
    reset = 1'b1;
    tick();
    chk("rst_rw", 64'(byp_regwrite), 64'd0);
    chk("rst_pend", 64'(byp_pending), 64'd0);
    chk("rst_data", 64'(|byp_data), 64'd0);
    chk("rst_wait", 64'(m2_wait), 64'd0);
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table run: E slot from the table, M1 from previous row, M3 from scoreboard
    drive_vec(vecs[0], 0);
    for (int c = 0; c < NVEC + 3; c++) begin
      tick();
      e_result[0] = (c < NVEC) ? vecs[c].e0 : 32'd0;
      e_result[1] = (c < NVEC) ? vecs[c].e1 : 32'd0;
      late_valid  = 2'b11;
      for (int l = 0; l < 2; l++) late_data[l] = (c >= 2 && c - 2 < NVEC) ? ld(c - 2, l) : 32'd0;
      if (c + 1 < NVEC) drive_vec(vecs[c + 1], c + 1);
      else begin iss_valid = '0; iss_regwrite = '0; end
      #1;
      if (c < NVEC) begin
        chk("e_rw", 64'(byp_regwrite[1:0]), 64'(vecs[c].exp_rw));
        chk("e_pend", 64'(byp_pending[1:0]), 64'(vecs[c].exp_pend));
        chk("e_d0", 64'(byp_data[0]), 64'(vecs[c].exp_d0));
        chk("e_d1", 64'(byp_data[1]), 64'(vecs[c].exp_d1));
      end
      if (c >= 1 && c - 1 < NVEC) begin
        chk("m1_d0", 64'(byp_data[2]), 64'(vecs[c - 1].exp_d0));
        chk("m1_d1", 64'(byp_data[3]), 64'(vecs[c - 1].exp_d1));
      end
      chk("tbl_wait", 64'(m2_wait), 64'd0);
      if (c >= 3) begin
        if (sbq.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          exp = sbq.pop_front();
          chk("m3_rw", 64'(byp_regwrite[7:6]), 64'(exp.rw));
          chk("m3_pend", 64'(byp_pending[7:6]), 64'd0);
          for (int l = 0; l < 2; l++) begin
            if (exp.rw[l]) chk("m3_rd", 64'(byp_rdst[6 + l]), 64'(exp.rd[l]));
            chk("m3_d", 64'(byp_data[6 + l]), 64'(exp.d[l]));
          end
        end
      end
    end
    idle();
    tick();
    chk("retired", 64'(byp_regwrite), 64'd0);

    // Lane1 load waits in M2, captures late data under stall, then moves to M3
    issue1(1, 5'd8, 1'b1);
    tick(); idle();
    tick();
    tick();
    chk("ld_wait", 64'(m2_wait), 64'd1);
    chk("ld_m2pend", 64'(byp_pending[5]), 64'd1);
    chk("ld_m2rd", 64'(byp_rdst[5]), 64'd8);
    chk("ld_cnt", 64'(pend_cnt), 64'd1);
    issue1(0, 5'd10, 1'b0);
    tick();
    chk("hold_wait", 64'(m2_wait), 64'd1);
    chk("hold_e", 64'(byp_regwrite[1:0]), 64'd0);
    chk("hold_m2rd", 64'(byp_rdst[5]), 64'd8);
    idle();
    stall = 1'b1; late_valid = 2'b10; late_data[1] = 32'hDEAD_BEEF;
    tick();
    chk("cap_pend", 64'(byp_pending[5]), 64'd0);
    chk("cap_data", 64'(byp_data[5]), 64'hDEAD_BEEF);
    chk("cap_cnt", 64'(pend_cnt), 64'd0);
    idle();
    #1;
    chk("cap_wait", 64'(m2_wait), 64'd0);
    tick();
    chk("ld_m3rw", 64'(byp_regwrite[7]), 64'd1);
    chk("ld_m3rd", 64'(byp_rdst[7]), 64'd8);
    chk("ld_m3d", 64'(byp_data[7]), 64'hDEAD_BEEF);
    tick(); tick();

    // Back-to-back delayed ops: pending count over E..M2
    late_valid = 2'b11;
    issue1(0, 5'd3, 1'b1);
    tick();
    chk("cnt1", 64'(pend_cnt), 64'd1);
    issue1(0, 5'd4, 1'b1);
    tick();
    chk("cnt2", 64'(pend_cnt), 64'd2);
    iss_valid = '0;
    tick();
    chk("cnt3", 64'(pend_cnt), 64'd2);
    tick();
    chk("cnt4", 64'(pend_cnt), 64'd1);
    tick();
    chk("cnt5", 64'(pend_cnt), 64'd0);
    tick(); tick();

    // flush_m1 kills E/M1 and bubbles M2 while the old M2 reaches M3
    idle();
    late_valid = 2'b11;
    issue1(0, 5'd1, 1'b0);
    tick(); e_result[0] = 32'h11; issue1(0, 5'd2, 1'b0);
    tick(); e_result[0] = 32'h22; issue1(0, 5'd3, 1'b0);
    tick(); e_result[0] = 32'h33; issue1(0, 5'd4, 1'b0); flush_m1 = 1'b1;
    tick();
    flush_m1 = 1'b0; iss_valid = '0;
    #1;
    chk("fl_e", 64'(byp_regwrite[1:0]), 64'd0);
    chk("fl_m1", 64'(byp_regwrite[3:2]), 64'd0);
    chk("fl_m2", 64'(byp_regwrite[5:4]), 64'd0);
    chk("fl_m3rw", 64'(byp_regwrite[6]), 64'd1);
    chk("fl_m3rd", 64'(byp_rdst[6]), 64'd1);
    chk("fl_m3d", 64'(byp_data[6]), 64'h11);
    tick(); tick();

    // Asynchronous reset while M2 waits on a late result
    idle();
    issue1(0, 5'd7, 1'b1);
    tick(); idle();
    tick(); tick();
    chk("ar_wait", 64'(m2_wait), 64'd1);
    e_result = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rw", 64'(byp_regwrite), 64'd0);
    chk("ar_pend", 64'(byp_pending), 64'd0);
    chk("ar_data", 64'(|byp_data), 64'd0);
    chk("ar_wait0", 64'(m2_wait), 64'd0);
    chk("ar_cnt", 64'(pend_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    issue1(0, 5'd9, 1'b0);
    tick();
    e_result[0] = 32'h99;
    iss_valid = '0;
    #1;
    chk("post_rw", 64'(byp_regwrite[0]), 64'd1);
    chk("post_rd", 64'(byp_rdst[0]), 64'd9);
    chk("post_d", 64'(byp_data[0]), 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
